// File: rtl/jtdd2_sub_pkg.sv
// Address map, shared RAM size and CPU state encoding for the DD2 sub-CPU block.
package jtdd2_sub_pkg;
  localparam int          SHARED_AW    = 9;        // 512-byte shared RAM
  localparam logic [15:0] ROM_TOP      = 16'hC000; // first non-ROM address
  localparam logic [3:0]  SHR_BASE     = 4'hC;     // C000-CFFF shared RAM (mirrored)
  localparam logic [3:0]  NMIACK_BASE  = 4'hD;     // D000-DFFF write: NMI ack
  localparam logic [3:0]  IRQMAIN_BASE = 4'hE;     // E000-EFFF write: IRQ to main

  // One state per bus cycle of the compact Z80-compatible core
  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_ARG1, S_ARG2, S_MEMRD, S_MEMWR, S_HALT, S_NMI
  } cpu_state_t;

  // True when the address lies in the given 4 KB page
  function automatic logic in_page(input logic [15:0] a, input logic [3:0] page);
    return a[15:12] == page;
  endfunction
endpackage

// File: rtl/jtdd2_sub_mcu_if.sv
// Main-CPU shared RAM port and sub ROM SDRAM slot, bundled.
// master = main CPU / SDRAM side, slave = sub-CPU subsystem.
interface jtdd2_sub_mcu_if;
  import jtdd2_sub_pkg::*;
  logic                 main_cen;
  logic [SHARED_AW-1:0] main_AB;
  logic                 main_wrn;
  logic [7:0]           main_dout;
  logic [7:0]           shared_dout;
  logic                 com_cs;
  logic [15:0]          rom_addr;
  logic [7:0]           rom_data;
  logic                 rom_cs;
  logic                 rom_ok;

  modport master (output main_cen, main_AB, main_wrn, main_dout, com_cs, rom_data, rom_ok,
                  input  shared_dout, rom_addr, rom_cs);
  modport slave  (input  main_cen, main_AB, main_wrn, main_dout, com_cs, rom_data, rom_ok,
                  output shared_dout, rom_addr, rom_cs);
endinterface

// File: rtl/jtdd2_sub_mcu_cpu.sv
// Compact Z80-compatible sub core: NOP, LD A,n, LD (nn),A, LD A,(nn), JP nn, HALT,
// RETN (ED xx) and edge-triggered NMI to 0066. One bus cycle per state, advanced by en.
module jtdd2_sub_mcu_cpu import jtdd2_sub_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rst,
  input  logic        en,
  input  logic        nmi_n,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        mreq,
  output logic        rd,
  output logic        wr,
  output logic        halt_n
);
  cpu_state_t  state_reg, state_next, end_state;
  logic [15:0] pc_reg, ret_pc_reg;
  logic [7:0]  op_reg, lo_reg, hi_reg, a_reg;
  logic        nmi_prev_reg, nmi_pend_reg;

  // State register; CPU reset parks the core with no bus cycle active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state_reg <= S_RST;
    else if (rst) state_reg <= S_RST;
    else          state_reg <= state_next;
  end

  // Next state and bus outputs; a pending NMI is taken at an instruction boundary
  always_comb begin
    state_next = state_reg;
    end_state  = nmi_pend_reg ? S_NMI : S_FETCH;
    addr       = pc_reg;
    dout       = a_reg;
    mreq       = 1'b0;
    rd         = 1'b0;
    wr         = 1'b0;
    halt_n     = 1'b1;
    case (state_reg)
      S_RST:   state_next = S_FETCH;
      S_FETCH: begin
        mreq = 1'b1; rd = 1'b1;
        if (en) begin
          case (din)
            8'h3E, 8'h32, 8'h3A, 8'hC3, 8'hED: state_next = S_ARG1;
            8'h76:                             state_next = S_HALT;
            default:                           state_next = end_state;
          endcase
        end
      end
      S_ARG1: begin
        mreq = 1'b1; rd = 1'b1;
        if (en) state_next = (op_reg == 8'h3E || op_reg == 8'hED) ? end_state : S_ARG2;
      end
      S_ARG2: begin
        mreq = 1'b1; rd = 1'b1;
        if (en) state_next = (op_reg == 8'h32) ? S_MEMWR :
                             (op_reg == 8'h3A) ? S_MEMRD : end_state;
      end
      S_MEMRD: begin
        addr = {hi_reg, lo_reg}; mreq = 1'b1; rd = 1'b1;
        if (en) state_next = end_state;
      end
      S_MEMWR: begin
        addr = {hi_reg, lo_reg}; mreq = 1'b1; wr = 1'b1;
        if (en) state_next = end_state;
      end
      S_HALT: begin
        halt_n = 1'b0;
        if (en && nmi_pend_reg) state_next = S_NMI;
      end
      S_NMI:   if (en) state_next = S_FETCH;
      default: state_next = S_RST;
    endcase
  end

  // Datapath: PC, operand bytes, accumulator, NMI edge detector and return address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= '0; ret_pc_reg <= '0; op_reg <= '0; lo_reg <= '0; hi_reg <= '0; a_reg <= '0;
      nmi_prev_reg <= 1'b1; nmi_pend_reg <= 1'b0;
    end else if (rst) begin
      pc_reg <= '0; ret_pc_reg <= '0; op_reg <= '0;
      nmi_prev_reg <= 1'b1; nmi_pend_reg <= 1'b0;
    end else begin
      nmi_prev_reg <= nmi_n;
      if (state_reg == S_NMI && en) nmi_pend_reg <= 1'b0;
      if (nmi_prev_reg && !nmi_n)   nmi_pend_reg <= 1'b1;
      if (en) begin
        case (state_reg)
          S_FETCH: begin op_reg <= din; pc_reg <= pc_reg + 16'd1; end
          S_ARG1: begin
            lo_reg <= din;
            pc_reg <= (op_reg == 8'hED) ? ret_pc_reg : pc_reg + 16'd1;
            if (op_reg == 8'h3E) a_reg <= din;
          end
          S_ARG2: begin
            hi_reg <= din;
            pc_reg <= (op_reg == 8'hC3) ? {din, lo_reg} : pc_reg + 16'd1;
          end
          S_MEMRD: a_reg <= din;
          S_NMI:   begin ret_pc_reg <= pc_reg; pc_reg <= 16'h0066; end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: rtl/jtdd2_sub_mcu.sv
// Double Dragon II sub-CPU subsystem: sub core, shared dual-port RAM, reset sync,
// NMI latch, IRQ-to-main pulse and SDRAM wait handling.
module jtdd2_sub_mcu import jtdd2_sub_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mcu_rstb,
  input  logic             cen4,
  input  logic             mcu_nmi_set,
  jtdd2_sub_mcu_if.slave   bus,
  output logic             mcu_halt,
  output logic             mcu_irqmain,
  output logic             mcu_ban
);
  logic [1:0]           rstb_sync_reg, hold_cnt_reg;
  logic                 cpu_rst_reg, new_cyc_reg, nmi_latch_reg, irqmain_reg;
  logic [7:0]           shared_dout_reg, sub_q_reg, cpu_dout, cpu_din;
  logic [15:0]          cpu_addr;
  logic                 cpu_mreq, cpu_rd, cpu_wr, cpu_halt_n, cpu_en, stall;
  logic                 rom_sel, shr_sel, rom_cs, main_we, sub_we, nmi_clr, irq_wr;
  logic [SHARED_AW-1:0] sub_a;
  logic [7:0]           shr_mem [2**SHARED_AW];

  assign rom_sel = cpu_addr < ROM_TOP;
  assign shr_sel = cpu_mreq && in_page(cpu_addr, SHR_BASE);
  assign rom_cs  = cpu_mreq && cpu_rd && rom_sel;
  // SDRAM stall plus one settle clock so the registered shared RAM read tracks a new address
  assign stall   = (rom_cs && !bus.rom_ok) || (shr_sel && cpu_rd && new_cyc_reg);
  assign cpu_en  = cen4 && !stall && !cpu_rst_reg;
  assign sub_a   = cpu_addr[SHARED_AW-1:0];
  assign main_we = bus.com_cs && !bus.main_wrn && bus.main_cen;
  assign sub_we  = shr_sel && cpu_wr && cpu_en;
  assign nmi_clr = cpu_mreq && cpu_wr && cpu_en && in_page(cpu_addr, NMIACK_BASE);
  assign irq_wr  = cpu_mreq && cpu_wr && cpu_en && in_page(cpu_addr, IRQMAIN_BASE);
  assign cpu_din = rom_sel ? bus.rom_data : (shr_sel ? sub_q_reg : 8'hFF);

  assign bus.rom_cs      = rom_cs;
  assign bus.rom_addr    = cpu_addr;
  assign bus.shared_dout = shared_dout_reg;
  assign mcu_halt        = cpu_rst_reg || !cpu_halt_n;
  assign mcu_ban         = shr_sel && !cpu_rst_reg;
  assign mcu_irqmain     = irqmain_reg;

  // Two-flop synchroniser for the main-CPU reset latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rstb_sync_reg <= 2'b00;
    else        rstb_sync_reg <= {rstb_sync_reg[0], mcu_rstb};
  end

  // Keep the core in reset for three cen4 ticks after the synchronised release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_reg <= 2'd0; cpu_rst_reg <= 1'b1;
    end else if (!rstb_sync_reg[1]) begin
      hold_cnt_reg <= 2'd0; cpu_rst_reg <= 1'b1;
    end else if (cpu_rst_reg && cen4) begin
      hold_cnt_reg <= hold_cnt_reg + 2'd1;
      if (hold_cnt_reg == 2'd2) cpu_rst_reg <= 1'b0;
    end
  end

  // Marks the first clock of every new bus cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) new_cyc_reg <= 1'b0;
    else        new_cyc_reg <= cpu_en;
  end

  // NMI latch: main sets, sub ack clears, set beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           nmi_latch_reg <= 1'b0;
    else if (cpu_rst_reg) nmi_latch_reg <= 1'b0;
    else if (mcu_nmi_set) nmi_latch_reg <= 1'b1;
    else if (nmi_clr)     nmi_latch_reg <= 1'b0;
  end

  // One clock IRQ pulse per completed write to the E000 page
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irqmain_reg <= 1'b0;
    else        irqmain_reg <= irq_wr;
  end

  // Shared RAM write ports; on a same-address collision only the main CPU write lands
  always_ff @(posedge clk) begin
    if (main_we) shr_mem[bus.main_AB] <= bus.main_dout;
    if (sub_we && !(main_we && bus.main_AB == sub_a)) shr_mem[sub_a] <= cpu_dout;
  end

  // Registered read ports (old data on read-during-write)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shared_dout_reg <= 8'h00; sub_q_reg <= 8'h00;
    end else begin
      shared_dout_reg <= shr_mem[bus.main_AB];
      sub_q_reg       <= shr_mem[sub_a];
    end
  end

  jtdd2_sub_mcu_cpu u_cpu (
    .clk    (clk),
    .rst_n  (rst_n),
    .rst    (cpu_rst_reg),
    .en     (cpu_en),
    .nmi_n  (!nmi_latch_reg),
    .din    (cpu_din),
    .addr   (cpu_addr),
    .dout   (cpu_dout),
    .mreq   (cpu_mreq),
    .rd     (cpu_rd),
    .wr     (cpu_wr),
    .halt_n (cpu_halt_n)
  );
endmodule

// File: tb/tb_jtdd2_sub_mcu.sv
// Directed bench for jtdd2_sub_mcu: ROM model with stall control, main-CPU
// shared RAM accesses checked through a scoreboard, NMI/IRQ/halt behaviour.
module tb_jtdd2_sub_mcu;
  logic clk = 1'b0;
  logic rst_n, mcu_rstb, cen4 = 1'b0, mcu_nmi_set;
  logic mcu_halt, mcu_irqmain, mcu_ban;
  int   checks = 0, errors = 0;

  jtdd2_sub_mcu_if bus();

  jtdd2_sub_mcu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mcu_rstb    (mcu_rstb),
    .cen4        (cen4),
    .mcu_nmi_set (mcu_nmi_set),
    .bus         (bus),
    .mcu_halt    (mcu_halt),
    .mcu_irqmain (mcu_irqmain),
    .mcu_ban     (mcu_ban)
  );

  always #5 clk = ~clk;

  // 4 MHz enable out of 24 MHz: one clock in six
  int cen_cnt = 0;
  always @(posedge clk) begin
    cen_cnt <= (cen_cnt == 5) ? 0 : cen_cnt + 1;
    cen4    <= (cen_cnt == 5);
  end

  // SDRAM slot model: one clock latency, rom_ok only once data matches the address
  logic [7:0]  rom_mem [256];
  logic [15:0] data_addr = 16'hFFFF;
  logic        stall = 1'b0;
  always @(posedge clk) begin
    bus.rom_data <= (bus.rom_addr < 16'd256) ? rom_mem[bus.rom_addr[7:0]] : 8'hFF;
    data_addr    <= bus.rom_addr;
  end
  assign bus.rom_ok = bus.rom_cs && !stall && (data_addr == bus.rom_addr);

  // Pulse/edge monitors
  int irq_edges = 0, irq_clks = 0, ban_edges = 0;
  logic irq_prev = 1'b0, ban_prev = 1'b0;
  always @(negedge clk) begin
    if (mcu_irqmain === 1'b1) irq_clks++;
    if (mcu_irqmain === 1'b1 && !irq_prev) irq_edges++;
    if (mcu_ban === 1'b1 && !ban_prev) ban_edges++;
    irq_prev = (mcu_irqmain === 1'b1);
    ban_prev = (mcu_ban === 1'b1);
  end

  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic main_write(input logic [8:0] a, input logic [7:0] d);
    bus.main_AB = a; bus.main_dout = d; bus.main_wrn = 1'b0; bus.com_cs = 1'b1; bus.main_cen = 1'b1;
    @(negedge clk);
    bus.main_wrn = 1'b1; bus.com_cs = 1'b0; bus.main_cen = 1'b0;
    $display("main write AB=%h data=%h", a, d);
  endtask

  task automatic main_read(input logic [8:0] a, input logic [7:0] exp);
    logic [7:0] e;
    bus.main_AB = a; bus.com_cs = 1'b1; bus.main_wrn = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.com_cs = 1'b0;
    e = exp_q.pop_front();
    $display("main read AB=%h data=%h", a, bus.shared_dout);
    check($sformatf("main_rd_%h", a), {8'h00, bus.shared_dout}, {8'h00, e});
  endtask

  task automatic wait_halt(input logic lvl, input string tag);
    int n = 0;
    while (mcu_halt !== lvl && n < 4000) begin @(negedge clk); n++; end
    check(tag, {15'd0, mcu_halt}, {15'd0, lvl});
  endtask

  task automatic wait_rom_cs(input string tag);
    int n = 0;
    while (bus.rom_cs !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    check(tag, {15'd0, bus.rom_cs}, 16'd1);
  endtask

  task automatic put(input int a, input logic [7:0] d);
    rom_mem[a] = d;
  endtask

  initial begin
    logic stable, found;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'h00;
    // Main program
    put(8'h00, 8'h3E); put(8'h01, 8'hA5);                    // LD A,A5
    put(8'h02, 8'h32); put(8'h03, 8'h10); put(8'h04, 8'hC0); // LD (C010),A
    put(8'h05, 8'h3A); put(8'h06, 8'hFF); put(8'h07, 8'hC1); // LD A,(C1FF)
    put(8'h08, 8'h32); put(8'h09, 8'h20); put(8'h0A, 8'hC0); // LD (C020),A
    put(8'h0B, 8'h3A); put(8'h0C, 8'hFF); put(8'h0D, 8'hCF); // LD A,(CFFF) mirror
    put(8'h0E, 8'h32); put(8'h0F, 8'h21); put(8'h10, 8'hC0); // LD (C021),A
    put(8'h11, 8'h32); put(8'h12, 8'h00); put(8'h13, 8'hE0); // LD (E000),A
    put(8'h14, 8'h32); put(8'h15, 8'h00); put(8'h16, 8'hE0); // LD (E000),A
    put(8'h17, 8'h76); put(8'h18, 8'h76); put(8'h19, 8'h76); put(8'h1A, 8'h76);
    // NMI handler
    put(8'h66, 8'h3E); put(8'h67, 8'h77);                    // LD A,77
    put(8'h68, 8'h32); put(8'h69, 8'h30); put(8'h6A, 8'hC0); // LD (C030),A
    put(8'h6B, 8'h32); put(8'h6C, 8'h00); put(8'h6D, 8'hD0); // LD (D000),A
    put(8'h6E, 8'hED); put(8'h6F, 8'h45);                    // RETN

    rst_n = 1'b0; mcu_rstb = 1'b0; mcu_nmi_set = 1'b0;
    bus.main_cen = 1'b0; bus.main_AB = '0; bus.main_wrn = 1'b1; bus.main_dout = '0; bus.com_cs = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_shared_dout", {8'h00, bus.shared_dout}, 16'h0000);
    check("rst_irqmain", {15'd0, mcu_irqmain}, 16'd0);
    check("rst_halt", {15'd0, mcu_halt}, 16'd1);
    check("rst_ban", {15'd0, mcu_ban}, 16'd0);
    check("rst_rom_cs", {15'd0, bus.rom_cs}, 16'd0);
    check("rst_rom_addr", bus.rom_addr, 16'h0000);
    check("rst_nmi_latch", {15'd0, dut.nmi_latch_reg}, 16'd0);

    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("held_halt", {15'd0, mcu_halt}, 16'd1);
    check("held_rom_cs", {15'd0, bus.rom_cs}, 16'd0);

    main_write(9'h1FF, 8'h5A);
    main_read(9'h1FF, 8'h5A);

    // Release with SDRAM stalled: first fetch at 0000 must hold
    stall = 1'b1; mcu_rstb = 1'b1;
    wait_rom_cs("first_fetch_cs");
    check("first_fetch_addr", bus.rom_addr, 16'h0000);
    check("run_halt", {15'd0, mcu_halt}, 16'd0);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.rom_addr !== 16'h0000 || bus.rom_cs !== 1'b1) stable = 1'b0;
    end
    check("stall_hold", {15'd0, stable}, 16'd1);
    stall = 1'b0;
    for (int n = 0; n < 50 && bus.rom_addr === 16'h0000; n++) @(negedge clk);
    check("fetch_done_addr", bus.rom_addr, 16'h0001);

    wait_halt(1'b1, "prog_halt");
    check("irq_pulses", 16'(irq_edges), 16'd2);
    check("irq_width", 16'(irq_clks), 16'd2);
    check("ban_accesses", 16'(ban_edges), 16'd5);
    check("ban_idle", {15'd0, mcu_ban}, 16'd0);
    main_read(9'h010, 8'hA5);
    main_read(9'h020, 8'h5A);
    main_read(9'h021, 8'h5A);

    // NMI: vector to 0066, handler acks and returns to HALT
    mcu_nmi_set = 1'b1; @(negedge clk); mcu_nmi_set = 1'b0;
    check("nmi_latch_set", {15'd0, dut.nmi_latch_reg}, 16'd1);
    wait_halt(1'b0, "nmi_wake");
    wait_rom_cs("nmi_fetch_cs");
    check("nmi_vector", bus.rom_addr, 16'h0066);
    wait_halt(1'b1, "nmi_rehalt");
    check("nmi_latch_ack", {15'd0, dut.nmi_latch_reg}, 16'd0);
    check("nmi_ban", 16'(ban_edges), 16'd6);
    main_read(9'h030, 8'h77);

    // Second NMI with a set landing on the same clock as the ack
    main_write(9'h030, 8'h00);
    mcu_nmi_set = 1'b1; @(negedge clk); mcu_nmi_set = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 4000 && !found; n++) begin
      @(negedge clk);
      if (dut.nmi_clr === 1'b1) begin mcu_nmi_set = 1'b1; found = 1'b1; end
    end
    check("nmi_ack_seen", {15'd0, found}, 16'd1);
    @(negedge clk); mcu_nmi_set = 1'b0;
    check("set_wins", {15'd0, dut.nmi_latch_reg}, 16'd1);
    wait_halt(1'b1, "nmi2_rehalt");
    main_read(9'h030, 8'h77);
    check("irq_total", 16'(irq_edges), 16'd2);

    // Sub reset while halted: latch cleared, RAM preserved
    mcu_rstb = 1'b0;
    repeat (4) @(negedge clk);
    check("sub_rst_halt", {15'd0, mcu_halt}, 16'd1);
    check("sub_rst_latch", {15'd0, dut.nmi_latch_reg}, 16'd0);
    main_read(9'h010, 8'hA5);

    // Reset during a stalled fetch aborts the bus cycle
    stall = 1'b1; mcu_rstb = 1'b1;
    wait_rom_cs("restart_cs");
    mcu_rstb = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_rom_cs", {15'd0, bus.rom_cs}, 16'd0);
    check("abort_halt", {15'd0, mcu_halt}, 16'd1);
    main_read(9'h1FF, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
